mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store stage between the single-cycle datapath and a data memory whose latency varies.
//  Takes the ALU address, the store data and the MemRead/MemWrite controls from the datapath.
//  Runs a req/ack transaction on the memory bus and returns load data on ReadData.
//  Holds the core with Stall until the access completes.
// PARAMETERS
//  ADDR_W          32  address width (the datapath ALUResult)
//  DATA_W          32  data width (the datapath RD2 / memReadData)
//  TIMEOUT_CYCLES  16  BUSY cycles before abort; only used when MEM_TIMEOUT_EN is defined
// PORTS
//  CLK         in   1       clock; all state updates on rising edge
//  RESET       in   1       asynchronous, active-high reset
//  c_MemRead   in   1       current instruction is a load
//  c_MemWrite  in   1       current instruction is a store
//  Addr        in   ADDR_W  byte address (ALUResult)
//  WriteData   in   DATA_W  store data (RD2)
//  ReadData    out  DATA_W  registered load data (to memReadData)
//  Stall       out  1       freeze PC register and RegWrite while 1
//  AlignErr    out  1       1-cycle pulse: access with Addr[1:0]!=0
//  BusErr      out  1       1-cycle pulse: access aborted by timeout
//  mem_req     out  1       bus request; registered
//  mem_we      out  1       1=write, 0=read; valid while mem_req
//  mem_addr    out  ADDR_W  word-aligned address; valid while mem_req
//  mem_wdata   out  DATA_W  write data; valid while mem_req
//  mem_ack     in   1       slave completes the transfer; sampled only in BUSY
//  mem_rdata   in   DATA_W  read data; valid with mem_ack on reads
// BEHAVIOUR
//  - Reset (async, RESET=1): state=IDLE.
//    Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadData=0, AlignErr=0, BusErr=0.
//    Stall=0 because state is IDLE.
//  - FSM states IDLE, BUSY, DONE.
//  - IDLE, no access (acc = c_MemRead|c_MemWrite = 0): Stall=0; stay in IDLE.
//  - IDLE, acc=1, Addr aligned:
//    - Stall=1 (combinational).
//    - Next edge: mem_req<=1; mem_we<=c_MemWrite; mem_addr<={Addr[31:2],2'b00}; mem_wdata<=WriteData.
//    - Go to BUSY.
//  - IDLE, acc=1, Addr[1:0]!=0: Stall=1; no bus request; go to DONE; AlignErr=1 during DONE.
//  - c_MemRead and c_MemWrite both 1: treated as a write; ReadData unchanged.
//  - BUSY: Stall=1. mem_req and all bus outputs held stable until mem_ack.
//  - BUSY, mem_ack=1 (the same cycle mem_req rises is allowed):
//    - Next edge: mem_req<=0.
//    - On a read: ReadData<=mem_rdata. On a write: ReadData is held.
//    - Go to DONE.
//  - DONE: Stall=0 for exactly 1 cycle; the core retires the instruction on that edge. Go to IDLE.
//    DONE never re-issues, even though c_MemRead/c_MemWrite are still high in that cycle.
//  - Minimum latency with zero-wait ack: 3 cycles per memory instruction (IDLE, BUSY, DONE).
//    Non-memory instructions: 1 cycle, no stall.
//  - mem_ack in IDLE or DONE is ignored.
//  - ReadData keeps its last value until the next completed read.
//  - RESET mid-transaction drops mem_req at once. The slave must tolerate an abandoned request.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//   - A counter clears on IDLE->BUSY and increments each BUSY cycle without ack.
//   - When the count reaches TIMEOUT_CYCLES with no ack:
//     mem_req<=0; ReadData<=0 on a read; go to DONE.
//   - BusErr=1 during that DONE cycle.
//   - If ack and timeout occur in the same cycle, the ack wins.
//  MEM_TIMEOUT_EN undefined: BUSY waits indefinitely; BusErr is tied to 0; no counter logic.
// STRUCTURE
//  - mem_pkg:
//    - typedef enum logic [1:0] {MA_IDLE, MA_BUSY, MA_DONE} ma_state_t;
//    - localparams for ADDR_W/DATA_W defaults;
//    - ALIGN_MASK = 2'b11.
//  - One sub-module, mem_watchdog (up-counter with clear, enable and terminal-count output).
//    Instantiated only under MEM_TIMEOUT_EN.
//  - The FSM and bus registers stay in mem_access_unit.
// TESTING
//  1. lw, Addr=0x40, ack in the same cycle as req, mem_rdata=0x1234_5678:
//     -> Stall high for 2 cycles; ReadData=0x1234_5678 in DONE; one req pulse with mem_we=0.
//  2. sw, Addr=0x44, WriteData=0xCAFE_F00D, ack after 5 wait cycles:
//     -> mem_we=1, mem_addr=0x44, mem_wdata stable for 6 cycles; Stall released in DONE.
//  3. lw, Addr=0x42 -> no mem_req; AlignErr pulses 1 cycle; Stall=1 for exactly 1 cycle.
//  4. RESET asserted mid-BUSY, then deasserted -> mem_req=0 immediately; state IDLE; ReadData=0.
//  5. MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, lw with ack never given:
//     -> mem_req drops after 16 BUSY cycles; BusErr pulse; ReadData=0.
//     Without the macro, Stall stays 1.
//  6. Back-to-back lw, sw, add, with ack 1 cycle after each req:
//     -> 4+4+1 cycles; no duplicate request in DONE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the load/store stage and its bus watchdog.
package mem_pkg;

    localparam int unsigned ADDR_W_DEF         = 32;
    localparam int unsigned DATA_W_DEF         = 32;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;
    localparam logic [1:0]  ALIGN_MASK         = 2'b11;

    typedef enum logic [1:0] {
        MA_IDLE,
        MA_BUSY,
        MA_DONE
    } ma_state_t;

endpackage

// File: rtl/mem_watchdog.sv
// Up-counter with clear and enable; tc_o flags the last permitted busy cycle.
module mem_watchdog #(
    parameter int unsigned TC = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CNT_W = $clog2(TC + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Fires on the TC-th consecutive enabled cycle so the abort lands on that edge.
    assign tc_o = en_i && (cnt_q == CNT_W'(TC - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: runs a req/ack transaction to data memory and stalls the core meanwhile.
// Define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES unacknowledged cycles (BusErr).
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              c_MemRead,
    input  logic              c_MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              AlignErr,
    output logic              BusErr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    ma_state_t         state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              align_q, align_d;
    logic              acc_c, misaligned_c, stall_c;

    assign acc_c        = c_MemRead | c_MemWrite;
    assign misaligned_c = (Addr[1:0] & ALIGN_MASK) != 2'b00;

`ifdef MEM_TIMEOUT_EN
    logic bus_err_q, bus_err_d;
    logic wd_clr_c, wd_en_c, timeout_c;

    assign wd_clr_c = (state_q == MA_IDLE) && acc_c && !misaligned_c;
    assign wd_en_c  = (state_q == MA_BUSY) && !mem_ack;

    mem_watchdog #(
        .TC(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i(CLK),
        .rst_i(RESET),
        .clr_i(wd_clr_c),
        .en_i (wd_en_c),
        .tc_o (timeout_c)
    );
`endif

    // Next-state, bus register updates and the combinational stall.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        align_d = 1'b0;
        stall_c = 1'b0;
`ifdef MEM_TIMEOUT_EN
        bus_err_d = 1'b0;
`endif
        case (state_q)
            MA_IDLE: begin
                stall_c = acc_c;
                if (acc_c) begin
                    if (misaligned_c) begin
                        align_d = 1'b1;
                        state_d = MA_DONE;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = c_MemWrite;
                        addr_d  = {Addr[ADDR_W-1:2], 2'b00};
                        wdata_d = WriteData;
                        state_d = MA_BUSY;
                    end
                end
            end
            MA_BUSY: begin
                stall_c = 1'b1;
                if (mem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = MA_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout_c) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = '0;
                    end
                    state_d = MA_DONE;
                end
`endif
            end
            MA_DONE: begin
                state_d = MA_IDLE;
            end
            default: begin
                state_d = MA_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= MA_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            align_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            align_q <= align_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

    assign BusErr = bus_err_q;
`else
    assign BusErr = 1'b0;
`endif

    assign Stall     = stall_c;
    assign ReadData  = rdata_q;
    assign AlignErr  = align_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset/hang sequences, random mix.
module tb_mem_access_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          c_MemRead, c_MemWrite;
    logic [AW-1:0] Addr;
    logic [DW-1:0] WriteData, ReadData;
    logic          Stall, AlignErr, BusErr;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    mem_access_unit #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .c_MemRead(c_MemRead), .c_MemWrite(c_MemWrite),
        .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
        .Stall(Stall), .AlignErr(AlignErr), .BusErr(BusErr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] rd, wr, addr, wdata;
        int          wait_n;
        logic [31:0] rdat;
        int          e_cyc, e_req;
        logic [31:0] e_we;
        int          e_align, e_bus;
        logic [31:0] e_rd;
    } vec_t;

    typedef struct {
        int          cycles, reqs, unstable, aligns, buserrs, timed_out;
        logic [31:0] we, addr, wdata, rdata, req_end;
    } obs_t;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string tag, string field, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", tag, field, act, exp);
        end
    endfunction

    // Acts as the core (holds the instruction until Stall drops) and as a wait-state slave.
    task automatic run_instr(input vec_t v, input bit noise, output obs_t o);
        int   waited;
        logic prev_req;
        logic st;
        o = '{default: 0};
        waited = 0;
        prev_req = 1'b0;
        c_MemRead  = v.rd[0];
        c_MemWrite = v.wr[0];
        Addr       = v.addr;
        WriteData  = v.wdata;
        for (int c = 0; c < 200; c++) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                if (!prev_req) begin
                    o.reqs++;
                    o.we    = 32'(mem_we);
                    o.addr  = mem_addr;
                    o.wdata = mem_wdata;
                end else if (32'(mem_we) !== o.we || mem_addr !== o.addr || mem_wdata !== o.wdata) begin
                    o.unstable++;
                end
                if (waited == v.wait_n) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdat;
                end else begin
                    waited++;
                end
            end else if (noise) begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            prev_req = mem_req;
            #1;
            o.cycles++;
            if (AlignErr) o.aligns++;
            if (BusErr) o.buserrs++;
            st        = Stall;
            o.rdata   = ReadData;
            o.req_end = 32'(mem_req);
            @(posedge CLK);
            #1;
            if (!st) return;
        end
        o.timed_out = 1;
    endtask

    task automatic check_obs(input string tag, input vec_t v, input obs_t o);
        chk(tag, "timeout", o.timed_out, 0);
        chk(tag, "cycles", o.cycles, v.e_cyc);
        chk(tag, "reqs", o.reqs, v.e_req);
        chk(tag, "align_err", o.aligns, v.e_align);
        chk(tag, "bus_err", o.buserrs, v.e_bus);
        chk(tag, "read_data", o.rdata, v.e_rd);
        chk(tag, "req_in_done", o.req_end, 0);
        if (v.e_req != 0) begin
            chk(tag, "bus_stable", o.unstable, 0);
            chk(tag, "mem_we", o.we, v.e_we);
            chk(tag, "mem_addr", o.addr, v.addr & 32'hFFFF_FFFC);
            chk(tag, "mem_wdata", o.wdata, v.wdata);
        end
    endtask

    vec_t        tbl[9];
    vec_t        v;
    obs_t        o;
    logic [31:0] rd_model;
    int          kind, stall_low;

    initial begin
        //           rd wr addr           wdata          wait rdat           cyc req we align bus rd
        tbl[0] = '{1, 0, 32'h0000_0040, 32'h0,          0, 32'h1234_5678, 3, 1, 0, 0, 0, 32'h1234_5678};
        tbl[1] = '{0, 1, 32'h0000_0044, 32'hCAFE_F00D,  5, 32'h0,         8, 1, 1, 0, 0, 32'h1234_5678};
        tbl[2] = '{1, 0, 32'h0000_0042, 32'h0,          0, 32'h0,         2, 0, 0, 1, 0, 32'h1234_5678};
        tbl[3] = '{1, 0, 32'h0000_0080, 32'h0,          1, 32'hA5A5_0001, 4, 1, 0, 0, 0, 32'hA5A5_0001};
        tbl[4] = '{0, 1, 32'h0000_0084, 32'h00C0_FFEE,  1, 32'h0,         4, 1, 1, 0, 0, 32'hA5A5_0001};
        tbl[5] = '{0, 0, 32'h0000_0003, 32'h0,          1, 32'h0,         1, 0, 0, 0, 0, 32'hA5A5_0001};
        tbl[6] = '{1, 1, 32'h0000_0048, 32'h0BAD_BEEF,  2, 32'hFFFF_FFFF, 5, 1, 1, 0, 0, 32'hA5A5_0001};
        tbl[7] = '{0, 1, 32'h0000_0047, 32'h1111_1111,  0, 32'h0,         2, 0, 0, 1, 0, 32'hA5A5_0001};
        tbl[8] = '{1, 0, 32'hFFFF_FFFC, 32'h0,          0, 32'h8000_0001, 3, 1, 0, 0, 0, 32'h8000_0001};

        RESET = 1'b1; c_MemRead = 1'b0; c_MemWrite = 1'b0; Addr = '0; WriteData = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset", "mem_req", 32'(mem_req), 0);
        chk("reset", "mem_we", 32'(mem_we), 0);
        chk("reset", "mem_addr", mem_addr, 0);
        chk("reset", "mem_wdata", mem_wdata, 0);
        chk("reset", "read_data", ReadData, 0);
        chk("reset", "align_err", 32'(AlignErr), 0);
        chk("reset", "bus_err", 32'(BusErr), 0);
        chk("reset", "stall", 32'(Stall), 0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_instr(tbl[i], 1'b0, o);
            check_obs($sformatf("vec%0d", i), tbl[i], o);
        end

        // Reset in the middle of a BUSY store
        c_MemRead = 1'b0; c_MemWrite = 1'b1; Addr = 32'h88; WriteData = 32'h1111_2222; mem_ack = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_busy", "req_up", 32'(mem_req), 1);
        repeat (2) @(posedge CLK);
        #2;
        c_MemWrite = 1'b0;
        RESET = 1'b1;
        #1;
        chk("rst_busy", "mem_req", 32'(mem_req), 0);
        chk("rst_busy", "mem_addr", mem_addr, 0);
        chk("rst_busy", "read_data", ReadData, 0);
        chk("rst_busy", "stall", 32'(Stall), 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        rd_model = 32'h0;
        v = '{1, 0, 32'h0000_0040, 32'h0, 0, 32'h5555_AAAA, 3, 1, 0, 0, 0, 32'h5555_AAAA};
        run_instr(v, 1'b0, o);
        check_obs("after_rst", v, o);
        rd_model = 32'h5555_AAAA;

        for (int i = 0; i < 60; i++) begin
            kind     = $urandom_range(0, 3);
            v.rd     = 32'(kind == 1 || kind == 3);
            v.wr     = 32'(kind >= 2);
            v.addr   = $urandom;
            if ($urandom_range(0, 3) != 0) v.addr = v.addr & 32'hFFFF_FFFC;
            v.wdata  = $urandom;
            v.wait_n = $urandom_range(0, 4);
            v.rdat   = $urandom;
            v.e_req = 0; v.e_align = 0; v.e_bus = 0; v.e_we = v.wr;
            if (v.rd == 0 && v.wr == 0) begin
                v.e_cyc = 1;
            end else if (v.addr % 4 != 0) begin
                v.e_cyc = 2;
                v.e_align = 1;
            end else begin
                v.e_cyc = 3 + v.wait_n;
                v.e_req = 1;
                if (v.rd != 0 && v.wr == 0) rd_model = v.rdat;
            end
            v.e_rd = rd_model;
            run_instr(v, 1'b1, o);
            check_obs($sformatf("rnd%0d", i), v, o);
        end

`ifdef MEM_TIMEOUT_EN
        v = '{1, 0, 32'h0000_0050, 32'h0, 1000000, 32'h0, 2 + int'(TO), 1, 0, 0, 1, 32'h0};
        run_instr(v, 1'b0, o);
        check_obs("timeout", v, o);
`else
        c_MemRead = 1'b1; c_MemWrite = 1'b0; Addr = 32'h50; mem_ack = 1'b0;
        stall_low = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!Stall) stall_low++;
            @(posedge CLK);
            #1;
        end
        chk("hang", "stall_low_cycles", stall_low, 0);
        chk("hang", "mem_req", 32'(mem_req), 1);
        chk("hang", "bus_err", 32'(BusErr), 0);
        c_MemRead = 1'b0;
        RESET = 1'b1;
        #1;
        RESET = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
